// File: rtl/key_step_ctrl.sv
// Single-step button conditioner: synchronizes and debounces the active-low key,
// emits one step strobe per accepted press (or periodic strobes in run mode) and counts them.
module key_step_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned CNT_W           = 20,
  parameter int unsigned RUN_PERIOD      = 25000000,
  parameter int unsigned RUN_W           = 25
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        key_n,
  input  logic        run_en,
  output logic        step_pulse,
  output logic        key_level,
  output logic [15:0] step_count
);

  localparam int unsigned STEP_CNT_W = 16;
  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(RUN_PERIOD - 1);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    PRESS_WAIT = 2'd1,
    PRESSED    = 2'd2,
    REL_WAIT   = 2'd3
  } state_e;

  state_e           state_q;
  state_e           state_d;
  logic [CNT_W-1:0] deb_cnt_q;
  logic [CNT_W-1:0] deb_cnt_d;
  logic [RUN_W-1:0] run_tmr_q;
  logic             sync1_n;
  logic             s_n;
  logic             press_accept_c;
  logic             run_wrap_c;
  logic             key_level_d;
  logic             step_pulse_d;

  // Two-flop synchronizer; idles at "released"
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_n <= 1'b1;
      s_n     <= 1'b1;
    end else begin
      sync1_n <= key_n;
      s_n     <= sync1_n;
    end
  end

  // Debounce FSM state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      deb_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      deb_cnt_q <= deb_cnt_d;
    end
  end

  // Debounce next-state: any sample disagreeing with the pending level restarts qualification
  always_comb begin
    state_d        = state_q;
    deb_cnt_d      = deb_cnt_q;
    press_accept_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (!s_n) begin
          state_d   = PRESS_WAIT;
          deb_cnt_d = CNT_W'(1);
        end
      end
      PRESS_WAIT: begin
        if (s_n) begin
          state_d   = IDLE;
          deb_cnt_d = '0;
        end else if (deb_cnt_q == DEB_LAST) begin
          state_d        = PRESSED;
          deb_cnt_d      = '0;
          press_accept_c = 1'b1;
        end else begin
          deb_cnt_d = deb_cnt_q + CNT_W'(1);
        end
      end
      PRESSED: begin
        if (s_n) begin
          state_d   = REL_WAIT;
          deb_cnt_d = CNT_W'(1);
        end
      end
      REL_WAIT: begin
        if (!s_n) begin
          state_d   = PRESSED;
          deb_cnt_d = '0;
        end else if (deb_cnt_q == DEB_LAST) begin
          state_d   = IDLE;
          deb_cnt_d = '0;
        end else begin
          deb_cnt_d = deb_cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d   = IDLE;
        deb_cnt_d = '0;
      end
    endcase
  end

  // Run-mode period timer; held at zero outside run mode so each entry gives a full period
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      run_tmr_q <= '0;
    end else if (!run_en) begin
      run_tmr_q <= '0;
    end else if (run_tmr_q == RUN_LAST) begin
      run_tmr_q <= '0;
    end else begin
      run_tmr_q <= run_tmr_q + RUN_W'(1);
    end
  end

  assign run_wrap_c  = run_en && (run_tmr_q == RUN_LAST);
  assign key_level_d = (state_d == PRESSED) || (state_d == REL_WAIT);

  // Gating on the current strobe keeps a mode switch from producing back-to-back pulses
  assign step_pulse_d = !step_pulse && (run_en ? run_wrap_c : press_accept_c);

  // Registered outputs and step counter
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      step_pulse <= 1'b0;
      key_level  <= 1'b0;
      step_count <= '0;
    end else begin
      step_pulse <= step_pulse_d;
      key_level  <= key_level_d;
      step_count <= step_count + STEP_CNT_W'(step_pulse);
    end
  end

endmodule

// File: tb/tb_key_step_ctrl.sv
// Self-checking bench for key_step_ctrl with short debounce/run periods.
module tb_key_step_ctrl;

  localparam int unsigned DEB = 4;
  localparam int unsigned PER = 8;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        key_n;
  logic        run_en;
  logic        step_pulse;
  logic        key_level;
  logic [15:0] step_count;

  int n_cmp = 0;
  int n_err = 0;

  key_step_ctrl #(
    .DEBOUNCE_CYCLES(DEB),
    .CNT_W          (3),
    .RUN_PERIOD     (PER),
    .RUN_W          (4)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .key_n     (key_n),
    .run_en    (run_en),
    .step_pulse(step_pulse),
    .key_level (key_level),
    .step_count(step_count)
  );

  always #5 clk = ~clk;

  // Reference model: key seen two edges late; level flips after DEB consecutive
  // disagreeing samples; run mode strobes every PER edges; count lags the strobe.
  bit          kh0, kh1;
  bit          m_level, m_pulse;
  int          m_run, m_ticks;
  logic [15:0] m_count;
  logic [15:0] count_base = 16'h0;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      kh0 = 1'b1; kh1 = 1'b1;
      m_level = 1'b0; m_pulse = 1'b0;
      m_run = 0; m_ticks = 0; m_count = 16'h0;
    end else begin
      bit s, accept, wrap;
      s = kh1; kh1 = kh0; kh0 = key_n;
      accept = 1'b0; wrap = 1'b0;
      if (s == m_level) begin
        m_run++;
        if (m_run == int'(DEB)) begin
          m_level = !m_level;
          m_run   = 0;
          accept  = m_level;
        end
      end else begin
        m_run = 0;
      end
      if (run_en) begin
        m_ticks++;
        if (m_ticks == int'(PER)) begin
          m_ticks = 0;
          wrap    = 1'b1;
        end
      end else begin
        m_ticks = 0;
      end
      m_count = m_count + 16'(m_pulse);
      m_pulse = !m_pulse && (run_en ? wrap : accept);
    end
  end

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset;
    reset_n = 1'b0; key_n = 1'b1; run_en = 1'b0;
    tick; tick;
    n_cmp++;
    if ({step_pulse, key_level, step_count} !== 18'h0) begin
      n_err++;
      $display("FAIL reset_state: got pulse=%b level=%b count=%h want 0/0/0000", step_pulse, key_level, step_count);
    end
    reset_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick;
      n_cmp++;
      if ({step_pulse, key_level, step_count} !== 18'h0) begin
        n_err++;
        $display("FAIL idle_quiet cyc %0d: got pulse=%b level=%b count=%h want 0/0/0000", i, step_pulse, key_level, step_count);
      end
    end
  endtask

  task automatic test_press_release;
    key_n = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick;
      n_cmp++;
      if (step_pulse !== (i == 5) || key_level !== (i >= 5) || step_pulse !== m_pulse) begin
        n_err++;
        $display("FAIL press edge %0d: got pulse=%b level=%b want pulse=%b level=%b", i, step_pulse, key_level, (i == 5), (i >= 5));
      end
    end
    n_cmp++;
    if (step_count !== 16'd1 || step_count !== m_count + count_base) begin
      n_err++;
      $display("FAIL press_count: got %0d want 1", step_count);
    end
    key_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick;
      n_cmp++;
      if (step_pulse !== 1'b0 || key_level !== (i < 5)) begin
        n_err++;
        $display("FAIL release edge %0d: got pulse=%b level=%b want pulse=0 level=%b", i, step_pulse, key_level, (i < 5));
      end
    end
  endtask

  task automatic test_bounce;
    logic [7:0] pat;
    logic [15:0] c0;
    pat = 8'b0010_0100;  // index i holds sample i: 0,0,1,0,0,1,0,0
    c0 = step_count;
    for (int i = 0; i < 24; i++) begin
      key_n = (i < 8) ? pat[i] : 1'b0;
      tick;
      n_cmp++;
      if (step_pulse !== (i == 11) || key_level !== (i >= 11) || key_level !== m_level) begin
        n_err++;
        $display("FAIL bounce edge %0d: got pulse=%b level=%b want pulse=%b level=%b", i, step_pulse, key_level, (i == 11), (i >= 11));
      end
    end
    n_cmp++;
    if (step_count !== c0 + 16'd1) begin
      n_err++;
      $display("FAIL bounce_count: got %0d want %0d", step_count, c0 + 16'd1);
    end
    key_n = 1'b1;
    for (int i = 0; i < 12; i++) tick;
  endtask

  task automatic test_run_mode;
    logic [15:0] c0;
    c0 = step_count;
    run_en = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      tick;
      n_cmp++;
      if (step_pulse !== (k % 8 == 0) || key_level !== (k >= 16) || step_pulse !== m_pulse) begin
        n_err++;
        $display("FAIL run tick %0d: got pulse=%b level=%b want pulse=%b level=%b", k, step_pulse, key_level, (k % 8 == 0), (k >= 16));
      end
      if (k == 10) key_n = 1'b0;
    end
    run_en = 1'b0;
    tick;
    n_cmp++;
    if (step_count !== c0 + 16'd5 || step_pulse !== 1'b0) begin
      n_err++;
      $display("FAIL run_count: got count=%0d pulse=%b want count=%0d pulse=0", step_count, step_pulse, c0 + 16'd5);
    end
    key_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick;
      n_cmp++;
      if (step_pulse !== 1'b0 || key_level !== m_level) begin
        n_err++;
        $display("FAIL run_release cyc %0d: got pulse=%b level=%b want pulse=0 level=%b", i, step_pulse, key_level, m_level);
      end
    end
  endtask

  task automatic test_count_wrap;
    count_base = 16'hFFFF - m_count;
    force dut.step_count = 16'hFFFF;
    tick;
    release dut.step_count;
    tick;
    n_cmp++;
    if (step_count !== 16'hFFFF) begin
      n_err++;
      $display("FAIL preload: got %h want ffff", step_count);
    end
    key_n = 1'b0;
    for (int i = 0; i < 7; i++) begin
      tick;
      n_cmp++;
      if (step_pulse !== (i == 5)) begin
        n_err++;
        $display("FAIL wrap_press edge %0d: got pulse=%b want %b", i, step_pulse, (i == 5));
      end
    end
    n_cmp++;
    if (step_count !== 16'h0000 || step_count !== m_count + count_base) begin
      n_err++;
      $display("FAIL count_wrap: got %h want 0000", step_count);
    end
    key_n = 1'b1;
    for (int i = 0; i < 12; i++) tick;
  endtask

  task automatic test_reset_mid;
    key_n = 1'b0;
    for (int i = 0; i < 5; i++) tick;  // edges E0..E4: counter now at 3
    n_cmp++;
    if (step_pulse !== 1'b0 || key_level !== 1'b0) begin
      n_err++;
      $display("FAIL pre_reset: got pulse=%b level=%b want 0/0", step_pulse, key_level);
    end
    reset_n = 1'b0;
    count_base = 16'h0;
    #1;
    n_cmp++;
    if ({step_pulse, key_level, step_count} !== 18'h0) begin
      n_err++;
      $display("FAIL async_reset: got pulse=%b level=%b count=%h want 0/0/0000", step_pulse, key_level, step_count);
    end
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick;
      n_cmp++;
      if (step_pulse !== (i == 5) || key_level !== (i >= 5)) begin
        n_err++;
        $display("FAIL post_reset edge %0d: got pulse=%b level=%b want pulse=%b level=%b", i, step_pulse, key_level, (i == 5), (i >= 5));
      end
    end
    key_n = 1'b1;
    for (int i = 0; i < 12; i++) tick;
  endtask

  task automatic test_random;
    int  hold;
    logic prev;
    hold = 0;
    for (int i = 0; i < 3000; i++) begin
      if (hold == 0) begin
        key_n = 1'($urandom_range(0, 1));
        hold  = int'($urandom_range(1, 9));
        if ($urandom_range(0, 15) == 0) run_en = !run_en;
      end
      hold--;
      prev = step_pulse;
      tick;
      n_cmp++;
      if (step_pulse !== m_pulse || key_level !== m_level || step_count !== m_count + count_base
          || (prev && step_pulse)) begin
        n_err++;
        $display("FAIL random cyc %0d: got pulse=%b level=%b count=%h want pulse=%b level=%b count=%h",
                 i, step_pulse, key_level, step_count, m_pulse, m_level, m_count + count_base);
      end
    end
    run_en = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0;
    key_n   = 1'b1;
    run_en  = 1'b0;
    test_reset;
    test_press_release;
    test_bounce;
    test_run_mode;
    test_count_wrap;
    test_reset_mid;
    test_random;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
